// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector load/store engines between the vector
// register file and data memory.
package vec_mem_pkg;

  localparam int N_WORDS_DEF = 16;
  localparam int WORD_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vec_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks which cycles carry valid read data: RD delayed by the memory latency,
// with a synchronous flush that drops every read still in flight.
module rd_lat_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic flush,
  input  logic rd,
  output logic vld
);

  logic [MEM_LAT-1:0] vld_p;

  if (MEM_LAT == 1) begin : g_one
    always_ff @(posedge Clk) begin
      if (Rst || flush) vld_p <= '0;
      else              vld_p <= rd;
    end
  end else begin : g_shift
    always_ff @(posedge Clk) begin
      if (Rst || flush) vld_p <= '0;
      else              vld_p <= {vld_p[MEM_LAT-2:0], rd};
    end
  end

  assign vld = vld_p[MEM_LAT-1];

endmodule

// File: rtl/mem_read_vld.sv
// Vector-load engine: issues N_WORDS consecutive reads, gathers the returning
// words in a shadow buffer and commits them to VectorReg in one edge.
module mem_read_vld
  import vec_mem_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      MR_en,
  input  logic [ADDR_W-1:0]         AddrIn,
  output logic [ADDR_W-1:0]         Addr,
  output logic                      RD,
  input  logic [WORD_W-1:0]         DataOut,
  output logic [N_WORDS*WORD_W-1:0] VectorReg,
  output logic                      done_vld
);

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  vec_state_e                state, state_nxt;
  logic [ADDR_W-1:0]         base, addr_d;
  logic [CNT_W-1:0]          issue_cnt, issue_inc, cap_cnt;
  logic [WORD_W-1:0]         shadow [N_WORDS];
  logic [N_WORDS*WORD_W-1:0] vec_merge;
  logic                      active, abort, cap_vld, capture, last_cap, last_issue;
  logic                      rd_d, done_d;

  assign active     = (state == ISSUE) || (state == DRAIN);
  assign abort      = active && !MR_en;
  assign capture    = active && MR_en && cap_vld;
  assign last_cap   = capture && (cap_cnt == LAST);
  assign last_issue = (state == ISSUE) && (issue_cnt == LAST);
  assign issue_inc  = issue_cnt + 1'b1;

  rd_lat_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_rd_lat_pipe (
    .Clk  (Clk),
    .Rst  (Rst),
    .flush(abort),
    .rd   (RD),
    .vld  (cap_vld)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (MR_en) state_nxt = ISSUE;
      ISSUE: begin
        if (abort)           state_nxt = IDLE;
        else if (last_cap)   state_nxt = DONE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_cap) state_nxt = DONE;
      end
      DONE:  if (!MR_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/strobe are registered, so they are derived from the state being entered.
  always_comb begin
    rd_d   = (state_nxt == ISSUE);
    done_d = last_cap;
    addr_d = Addr;
    if (state == IDLE && state_nxt == ISSUE)
      addr_d = AddrIn;
    else if (state == ISSUE && state_nxt == ISSUE)
      addr_d = base + ADDR_W'(issue_inc);
  end

  // The final word bypasses the shadow buffer so the commit happens on its capture edge.
  always_comb begin
    vec_merge = '0;
    for (int i = 0; i < N_WORDS; i++)
      vec_merge[i*WORD_W +: WORD_W] = (cap_cnt == CNT_W'(i)) ? DataOut : shadow[i];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Addr      <= '0;
      RD        <= 1'b0;
      done_vld  <= 1'b0;
      VectorReg <= '0;
      base      <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      for (int i = 0; i < N_WORDS; i++) shadow[i] <= '0;
    end else begin
      RD       <= rd_d;
      Addr     <= addr_d;
      done_vld <= done_d;
      if (state == IDLE && MR_en) begin
        base      <= AddrIn;
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end
      if (state == ISSUE && state_nxt == ISSUE) issue_cnt <= issue_inc;
      if (capture) begin
        shadow[cap_cnt] <= DataOut;
        cap_cnt         <= cap_cnt + 1'b1;
      end
      if (last_cap) VectorReg <= vec_merge;
    end
  end

endmodule

// File: tb/tb_mem_read_vld.sv
// Bench for mem_read_vld: a 1-cycle and a 3-cycle latency instance share one
// stimulus stream; a queue scoreboard holds expected addresses and vectors.
module tb_mem_read_vld;

  logic         Clk = 1'b0;
  logic         Rst, MR_en;
  logic [15:0]  AddrIn;
  logic [15:0]  Addr, Addr3;
  logic         RD, RD3;
  logic [15:0]  DataOut, DataOut3;
  logic [255:0] VectorReg, VectorReg3;
  logic         done_vld, done_vld3;
  logic [15:0]  d1, d3a, d3b, d3c;

  int checks = 0;
  int passed = 0;

  logic [15:0]  addr_q[$];
  logic [255:0] vec_q[$];
  logic [255:0] vec3_q[$];

  always #5 Clk = ~Clk;

  mem_read_vld #(.N_WORDS(16), .WORD_W(16), .ADDR_W(16), .MEM_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .MR_en(MR_en), .AddrIn(AddrIn), .Addr(Addr), .RD(RD),
    .DataOut(DataOut), .VectorReg(VectorReg), .done_vld(done_vld)
  );

  mem_read_vld #(.N_WORDS(16), .WORD_W(16), .ADDR_W(16), .MEM_LAT(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .MR_en(MR_en), .AddrIn(AddrIn), .Addr(Addr3), .RD(RD3),
    .DataOut(DataOut3), .VectorReg(VectorReg3), .done_vld(done_vld3)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [255:0] exp_vec(input logic [15:0] base);
    logic [15:0] a;
    exp_vec = '0;
    for (int i = 0; i < 16; i++) begin
      a = base + 16'(i);
      exp_vec[i*16 +: 16] = mem_f(a);
    end
  endfunction

  // Memory models: address registered on the edge, data valid MEM_LAT cycles after RD.
  always @(posedge Clk) begin
    d1  <= mem_f(Addr);
    d3a <= mem_f(Addr3);
    d3b <= d3a;
    d3c <= d3b;
  end
  assign DataOut  = d1;
  assign DataOut3 = d3c;

  task automatic idle(input int n);
    MR_en = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] base);
    for (int i = 0; i < 16; i++) addr_q.push_back(base + 16'(i));
    vec_q.push_back(exp_vec(base));
    AddrIn = base;
    MR_en  = 1'b1;
  endtask

  task automatic test_reset;
    Rst = 1'b1; MR_en = 1'b1; AddrIn = 16'h0100;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (Addr !== 16'h0) $display("FAIL reset_addr: got %h want 0000", Addr); else passed++;
    checks++; if (RD !== 1'b0) $display("FAIL reset_rd: got %b want 0", RD); else passed++;
    checks++; if (VectorReg !== '0) $display("FAIL reset_vec: got %h want 0", VectorReg); else passed++;
    checks++; if (done_vld !== 1'b0) $display("FAIL reset_done: got %b want 0", done_vld); else passed++;
    checks++; if (RD3 !== 1'b0 || VectorReg3 !== '0) $display("FAIL reset_lat3: rd %b vec %h want 0", RD3, VectorReg3); else passed++;
    Rst = 1'b0;
    @(posedge Clk); #1;
    checks++; if (RD !== 1'b1 || Addr !== 16'h0100) $display("FAIL start_after_rst: rd %b addr %h want 1 0100", RD, Addr); else passed++;
    MR_en = 1'b0;
    @(posedge Clk); #1;
    checks++; if (RD !== 1'b0) $display("FAIL early_abort_rd: got %b want 0", RD); else passed++;
    idle(6);
  endtask

  task automatic test_basic;
    int rd_n = 0, rd3_n = 0, first_rd = 0, done_n = 0, done_cyc = 0, done3_cyc = 0;
    logic [15:0]  ea;
    logic [255:0] ev;
    addr_q.delete(); vec_q.delete(); vec3_q.delete();
    start_load(16'h0100);
    vec3_q.push_back(exp_vec(16'h0100));
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clk); #1;
      if (c == 2) AddrIn = 16'hDEAD;
      if (RD3) rd3_n++;
      if (RD) begin
        rd_n++;
        if (first_rd == 0) first_rd = c;
        checks++;
        if (addr_q.size() == 0) $display("FAIL basic_addr_extra c%0d: got %h want none", c, Addr);
        else begin
          ea = addr_q.pop_front();
          if (Addr !== ea) $display("FAIL basic_addr c%0d: got %h want %h", c, Addr, ea); else passed++;
        end
      end
      if (done_vld) begin
        done_n++; done_cyc = c; checks++;
        if (vec_q.size() == 0) $display("FAIL basic_vec_extra c%0d: got %h want none", c, VectorReg);
        else begin
          ev = vec_q.pop_front();
          if (VectorReg !== ev) $display("FAIL basic_vec: got %h want %h", VectorReg, ev); else passed++;
        end
      end
      if (done_vld3) begin
        done3_cyc = c; checks++;
        if (vec3_q.size() == 0) $display("FAIL lat3_vec_extra c%0d: got %h want none", c, VectorReg3);
        else begin
          ev = vec3_q.pop_front();
          if (VectorReg3 !== ev) $display("FAIL lat3_vec: got %h want %h", VectorReg3, ev); else passed++;
        end
      end
    end
    checks++; if (rd_n !== 16 || first_rd !== 1) $display("FAIL basic_rd_window: cycles %0d first %0d want 16 1", rd_n, first_rd); else passed++;
    checks++; if (done_cyc !== 18 || done_n !== 1) $display("FAIL basic_done: cycle %0d pulses %0d want 18 1", done_cyc, done_n); else passed++;
    checks++; if (VectorReg[15:0] !== 16'h5B5A) $display("FAIL basic_lane0: got %h want 5b5a", VectorReg[15:0]); else passed++;
    checks++; if (VectorReg[255:240] !== 16'h5B55) $display("FAIL basic_lane15: got %h want 5b55", VectorReg[255:240]); else passed++;
    checks++; if (addr_q.size() !== 0) $display("FAIL basic_addr_missing: got %0d left want 0", addr_q.size()); else passed++;
    checks++; if (done3_cyc !== 20 || rd3_n !== 16) $display("FAIL lat3_timing: done cycle %0d rd %0d want 20 16", done3_cyc, rd3_n); else passed++;
  endtask

  task automatic test_wrap;
    int done_n = 0;
    logic [15:0]  ea;
    logic [255:0] ev;
    idle(2);
    addr_q.delete(); vec_q.delete();
    start_load(16'hFFF8);
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      if (RD) begin
        checks++;
        if (addr_q.size() == 0) $display("FAIL wrap_addr_extra c%0d: got %h want none", c, Addr);
        else begin
          ea = addr_q.pop_front();
          if (Addr !== ea) $display("FAIL wrap_addr c%0d: got %h want %h", c, Addr, ea); else passed++;
        end
      end
      if (done_vld) begin
        done_n++; checks++;
        if (vec_q.size() == 0) $display("FAIL wrap_vec_extra: got %h want none", VectorReg);
        else begin
          ev = vec_q.pop_front();
          if (VectorReg !== ev) $display("FAIL wrap_vec: got %h want %h", VectorReg, ev); else passed++;
        end
      end
    end
    checks++; if (VectorReg[143:128] !== 16'h5A5A) $display("FAIL wrap_lane8: got %h want 5a5a", VectorReg[143:128]); else passed++;
    checks++; if (done_n !== 1 || addr_q.size() !== 0) $display("FAIL wrap_count: done %0d addr left %0d want 1 0", done_n, addr_q.size()); else passed++;
  endtask

  task automatic test_back_to_back;
    int rd_n = 0, done_n = 0, done_cyc = 0, held_bad = 0;
    logic         seen = 1'b0;
    logic [255:0] va, ev;
    idle(2);
    addr_q.delete(); vec_q.delete();
    start_load(16'h2000);
    va = exp_vec(16'h2000);
    for (int c = 1; c <= 30; c++) begin
      @(posedge Clk); #1;
      if (RD) rd_n++;
      if (done_vld) done_n++;
    end
    checks++; if (VectorReg !== va) $display("FAIL b2b_vec_a: got %h want %h", VectorReg, va); else passed++;
    checks++; if (rd_n !== 16 || done_n !== 1) $display("FAIL b2b_no_retrigger: rd %0d done %0d want 16 1", rd_n, done_n); else passed++;
    addr_q.delete(); vec_q.delete();
    MR_en = 1'b0;
    @(posedge Clk); #1;
    start_load(16'h3000);
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      if (done_vld) begin
        seen = 1'b1; done_cyc = c; checks++;
        if (vec_q.size() == 0) $display("FAIL b2b_vec_extra: got %h want none", VectorReg);
        else begin
          ev = vec_q.pop_front();
          if (VectorReg !== ev) $display("FAIL b2b_vec_b: got %h want %h", VectorReg, ev); else passed++;
        end
      end else if (!seen && VectorReg !== va) held_bad++;
    end
    checks++; if (held_bad !== 0) $display("FAIL b2b_hold_a: got %0d bad cycles want 0", held_bad); else passed++;
    checks++; if (done_cyc !== 18) $display("FAIL b2b_done_cycle: got %0d want 18", done_cyc); else passed++;
  endtask

  task automatic test_abort;
    int rd_n = 0, done_n = 0, done_cyc = 0;
    logic         rd10 = 1'b1;
    logic [15:0]  ea;
    logic [255:0] prev, ev;
    idle(2);
    prev = VectorReg;
    addr_q.delete(); vec_q.delete();
    start_load(16'h4000);
    vec_q.delete();
    for (int c = 1; c <= 30; c++) begin
      @(posedge Clk); #1;
      if (c == 9) MR_en = 1'b0;
      if (c == 10) rd10 = RD;
      if (done_vld) done_n++;
      if (RD) begin
        rd_n++; checks++;
        if (addr_q.size() == 0) $display("FAIL abort_addr_extra c%0d: got %h want none", c, Addr);
        else begin
          ea = addr_q.pop_front();
          if (Addr !== ea) $display("FAIL abort_addr c%0d: got %h want %h", c, Addr, ea); else passed++;
        end
      end
    end
    checks++; if (rd10 !== 1'b0 || rd_n !== 9) $display("FAIL abort_rd: cycle10 %b count %0d want 0 9", rd10, rd_n); else passed++;
    checks++; if (done_n !== 0) $display("FAIL abort_done: got %0d pulses want 0", done_n); else passed++;
    checks++; if (VectorReg !== prev) $display("FAIL abort_vec_kept: got %h want %h", VectorReg, prev); else passed++;
    addr_q.delete(); vec_q.delete();
    start_load(16'h5000);
    addr_q.delete();
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); #1;
      if (done_vld) begin
        done_cyc = c; checks++;
        if (vec_q.size() == 0) $display("FAIL reload_vec_extra: got %h want none", VectorReg);
        else begin
          ev = vec_q.pop_front();
          if (VectorReg !== ev) $display("FAIL reload_vec: got %h want %h", VectorReg, ev); else passed++;
        end
      end
    end
    checks++; if (done_cyc !== 18) $display("FAIL reload_done_cycle: got %0d want 18", done_cyc); else passed++;
  endtask

  task automatic test_reset_drain;
    idle(2);
    addr_q.delete(); vec_q.delete();
    start_load(16'h6000);
    addr_q.delete(); vec_q.delete();
    repeat (17) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    checks++; if (Addr !== 16'h0 || RD !== 1'b0) $display("FAIL drain_rst_bus: addr %h rd %b want 0000 0", Addr, RD); else passed++;
    checks++; if (VectorReg !== '0) $display("FAIL drain_rst_vec: got %h want 0", VectorReg); else passed++;
    checks++; if (done_vld !== 1'b0) $display("FAIL drain_rst_done: got %b want 0", done_vld); else passed++;
    MR_en = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    checks++; if (done_vld !== 1'b0 || RD !== 1'b0) $display("FAIL drain_rst_idle: done %b rd %b want 0 0", done_vld, RD); else passed++;
  endtask

  initial begin
    Rst = 1'b1; MR_en = 1'b0; AddrIn = 16'h0;
    @(posedge Clk); #1;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
